// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase sequencer: prescaler tick, counter enable, shadow ARR/PSC/mode,
// repetition counter, one-pulse stop and software-forced update.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | counter stopped, waiting for cfg_en to start a run
// RUN     | counter enabled, prescaler ticking
// RESTART | one cycle with pwm_en low so the counter and direction clear
// DONE    | one-pulse run finished; cfg_en must drop before re-arming
module pwm_timebase_ctrl #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 16,
  parameter int RCR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_mode,
  input  logic             cfg_opm,
  input  logic             cfg_arpe,
  input  logic [WIDTH-1:0] cfg_arr,
  input  logic [PSC_W-1:0] cfg_psc,
  input  logic [RCR_W-1:0] cfg_rcr,
  input  logic             ug,
  input  logic             uif_clr,
  input  logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             pwm_en,
  output logic             mode_act,
  output logic [WIDTH-1:0] arr_act,
  output logic             uev,
  output logic             uif,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESTART = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PSC_W-1:0] psc_act;
  logic [PSC_W-1:0] psc_cnt;
  logic [RCR_W-1:0] rep_cnt;
  logic             ovf;
  logic             uev_set;
  logic             enter_run;

  // The >= compare lets a counter stranded above a shrunken ARR wrap on the next tick.
  assign tick      = (state == ST_RUN) && (psc_cnt == psc_act);
  assign ovf       = tick && pwm_en && (cnt >= arr_act);
  assign uev_set   = ug || (ovf && (rep_cnt == '0));
  assign enter_run = (state == ST_IDLE) && cfg_en;
  assign busy      = (state == ST_RUN) || (state == ST_RESTART);

  // Next-state decode; dropping cfg_en always returns to IDLE first.
  always_comb begin
    state_nxt = state;
    if (!cfg_en) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    state_nxt = ST_RUN;
        ST_RUN: begin
          if (ug)
            state_nxt = ST_RESTART;
          else if (ovf && (rep_cnt == '0) && cfg_opm)
            state_nxt = ST_DONE;
        end
        ST_RESTART: state_nxt = ST_RUN;
        ST_DONE:    state_nxt = ST_DONE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, counter enable, prescaler divider and update flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pwm_en  <= 1'b0;
      psc_cnt <= '0;
      uev     <= 1'b0;
      uif     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwm_en  <= (state_nxt == ST_RUN);
      psc_cnt <= ((state == ST_RUN) && (state_nxt == ST_RUN) && !tick) ?
                 psc_cnt + 1'b1 : '0;
      uev     <= uev_set;
      if (uev_set)
        uif <= 1'b1;
      else if (uif_clr)
        uif <= 1'b0;
    end
  end

  // Shadow registers: mode only at start of a run, ARR/PSC/RCR at start or update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_act <= 1'b0;
      arr_act  <= '0;
      psc_act  <= '0;
      rep_cnt  <= '0;
    end else begin
      if (enter_run)
        mode_act <= cfg_mode;
      if (enter_run || !cfg_arpe || uev_set)
        arr_act <= cfg_arr;
      if (enter_run || uev_set) begin
        psc_act <= cfg_psc;
        rep_cnt <= cfg_rcr;
      end else if (ovf) begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Bench for pwm_timebase_ctrl: a fixed vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model plus a counter model.
module tb_pwm_timebase_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_RESTART = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en, cfg_mode, cfg_opm, cfg_arpe;
  logic [15:0] cfg_arr, cfg_psc;
  logic [7:0]  cfg_rcr;
  logic        ug, uif_clr;
  logic [15:0] cnt;
  logic        tick, pwm_en, mode_act, uev, uif, busy;
  logic [15:0] arr_act;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int          m_st;
  logic [15:0] m_arr, m_psc, m_div;
  logic [7:0]  m_rep;
  bit          m_mode, m_uev, m_uif;
  // external counter model
  logic [15:0] e_cnt;
  bit          e_down;
  bit          use_env;

  pwm_timebase_ctrl #(.WIDTH(16), .PSC_W(16), .RCR_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_opm(cfg_opm),
    .cfg_arpe(cfg_arpe), .cfg_arr(cfg_arr), .cfg_psc(cfg_psc), .cfg_rcr(cfg_rcr),
    .ug(ug), .uif_clr(uif_clr), .cnt(cnt), .tick(tick), .pwm_en(pwm_en),
    .mode_act(mode_act), .arr_act(arr_act), .uev(uev), .uif(uif), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict from the rules, clock the DUT, compare all outputs.
  task automatic step();
    bit          run, tk, ovf, fire, enter;
    int          nst;
    logic [15:0] ncnt;
    bit          ndown;
    if (use_env) cnt = e_cnt;
    run   = (m_st == M_RUN);
    tk    = run && (m_div == m_psc);
    ovf   = tk && (cnt >= m_arr);
    fire  = ug || (ovf && (m_rep == 0));
    enter = (m_st == M_IDLE) && cfg_en;
    if (!cfg_en)                nst = M_IDLE;
    else if (m_st == M_IDLE)    nst = M_RUN;
    else if (m_st == M_RESTART) nst = M_RUN;
    else if (m_st == M_DONE)    nst = M_DONE;
    else if (ug)                nst = M_RESTART;
    else if (ovf && m_rep == 0 && cfg_opm) nst = M_DONE;
    else                        nst = M_RUN;
    ncnt = e_cnt; ndown = e_down;
    if (!run) begin
      ncnt = 0; ndown = 0;
    end else if (tk) begin
      if (!m_mode) begin
        ncnt = (cnt >= m_arr) ? 16'd0 : cnt + 16'd1; ndown = 0;
      end else if (!e_down) begin
        if (cnt >= m_arr) begin ndown = 1; ncnt = (cnt == 0) ? 16'd0 : cnt - 16'd1; end
        else ncnt = cnt + 16'd1;
      end else begin
        if (cnt == 0) begin ndown = 0; ncnt = 16'd1; end
        else ncnt = cnt - 16'd1;
      end
    end
    @(posedge clk);
    if (rst) begin
      m_st = M_IDLE; m_arr = 0; m_psc = 0; m_div = 0; m_rep = 0;
      m_mode = 0; m_uev = 0; m_uif = 0; e_cnt = 0; e_down = 0;
    end else begin
      m_div  = (run && nst == M_RUN && !tk) ? m_div + 16'd1 : 16'd0;
      if (enter) m_mode = cfg_mode;
      if (enter || !cfg_arpe || fire) m_arr = cfg_arr;
      if (enter || fire) begin m_psc = cfg_psc; m_rep = cfg_rcr; end
      else if (ovf) m_rep = m_rep - 8'd1;
      m_uev  = fire;
      m_uif  = fire ? 1'b1 : (uif_clr ? 1'b0 : m_uif);
      m_st   = nst;
      e_cnt  = ncnt; e_down = ndown;
    end
    #1;
    check("tick",     tick,     (m_st == M_RUN) && (m_div == m_psc));
    check("pwm_en",   pwm_en,   m_st == M_RUN);
    check("busy",     busy,     (m_st == M_RUN) || (m_st == M_RESTART));
    check("mode_act", mode_act, m_mode);
    check("arr_act",  arr_act,  m_arr);
    check("uev",      uev,      m_uev);
    check("uif",      uif,      m_uif);
  endtask

  task automatic do_reset();
    rst = 1; cfg_en = 0; ug = 0; uif_clr = 0;
    step();
    rst = 0;
  endtask

  task automatic run_measure(input int ncyc, output int period);
    int last = -1, prev = -1;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (uev) begin prev = last; last = i; end
    end
    period = (prev >= 0) ? last - prev : -1;
  endtask

  typedef struct {
    bit rst, en, mode, opm, arpe;
    logic [15:0] arr, psc;
    logic [7:0]  rcr;
    bit ug, clr;
    logic [15:0] cnt;
    bit e_pwm, e_tick;
    logic [15:0] e_arr;
    bit e_uev, e_uif, e_busy, e_mode;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int period;
    bit found;
    // rst en mode opm arpe arr psc rcr ug clr cnt | pwm tick arr uev uif busy mode
    vecs[0]  = '{1,0,0,0,1, 0,0,0, 0,0, 0,  0,0,0, 0,0,0,0};
    vecs[1]  = '{0,1,1,1,1, 2,0,0, 0,0, 0,  1,1,2, 0,0,1,1};
    vecs[2]  = '{0,1,1,1,1, 2,0,0, 0,0, 0,  1,1,2, 0,0,1,1};
    vecs[3]  = '{0,1,1,1,1, 2,0,0, 0,0, 1,  1,1,2, 0,0,1,1};
    vecs[4]  = '{0,1,1,1,1, 5,0,0, 0,0, 2,  0,0,5, 1,1,0,1};
    vecs[5]  = '{0,1,1,1,1, 5,0,0, 0,0, 0,  0,0,5, 0,1,0,1};
    vecs[6]  = '{0,0,1,1,1, 5,0,0, 0,0, 0,  0,0,5, 0,1,0,1};
    vecs[7]  = '{0,1,0,1,1, 5,0,0, 0,1, 0,  1,1,5, 0,0,1,0};
    vecs[8]  = '{0,1,0,1,1, 5,0,0, 1,1, 0,  0,0,5, 1,1,1,0};
    vecs[9]  = '{0,1,0,1,1, 5,0,0, 0,0, 0,  1,1,5, 0,1,1,0};
    vecs[10] = '{0,1,0,1,0, 1,0,0, 0,0, 3,  1,1,1, 0,1,1,0};
    vecs[11] = '{0,1,0,0,0, 1,0,0, 0,0, 3,  1,1,1, 1,1,1,0};
    vecs[12] = '{1,1,0,0,0, 1,0,0, 0,0, 0,  0,0,0, 0,0,0,0};

    rst = 1; cfg_en = 0; cfg_mode = 0; cfg_opm = 0; cfg_arpe = 1;
    cfg_arr = 0; cfg_psc = 0; cfg_rcr = 0; ug = 0; uif_clr = 0; cnt = 0;
    m_st = M_IDLE; m_arr = 0; m_psc = 0; m_div = 0; m_rep = 0;
    m_mode = 0; m_uev = 0; m_uif = 0; e_cnt = 0; e_down = 0; use_env = 0;
    @(negedge clk);

    // vector table, cnt driven directly
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; cfg_en = vecs[i].en; cfg_mode = vecs[i].mode;
      cfg_opm = vecs[i].opm; cfg_arpe = vecs[i].arpe; cfg_arr = vecs[i].arr;
      cfg_psc = vecs[i].psc; cfg_rcr = vecs[i].rcr; ug = vecs[i].ug;
      uif_clr = vecs[i].clr; cnt = vecs[i].cnt;
      step();
      check($sformatf("vec%0d_pwm_en", i),   pwm_en,   vecs[i].e_pwm);
      check($sformatf("vec%0d_tick", i),     tick,     vecs[i].e_tick);
      check($sformatf("vec%0d_arr_act", i),  arr_act,  vecs[i].e_arr);
      check($sformatf("vec%0d_uev", i),      uev,      vecs[i].e_uev);
      check($sformatf("vec%0d_uif", i),      uif,      vecs[i].e_uif);
      check($sformatf("vec%0d_busy", i),     busy,     vecs[i].e_busy);
      check($sformatf("vec%0d_mode_act", i), mode_act, vecs[i].e_mode);
    end

    use_env = 1;
    ug = 0; uif_clr = 0; cfg_arpe = 1; cfg_opm = 0;

    // up mode, psc=1, arr=3: update every 8 clocks
    do_reset();
    cfg_psc = 1; cfg_arr = 3; cfg_mode = 0; cfg_rcr = 0; cfg_en = 1;
    run_measure(40, period);
    check("uev_period_up", period, 8);

    // repetition 2: update every 24 clocks
    do_reset();
    cfg_rcr = 2; cfg_en = 1;
    run_measure(80, period);
    check("uev_period_rcr2", period, 24);

    // up-down, arr=3, psc=0: peak every 6 clocks
    do_reset();
    cfg_mode = 1; cfg_psc = 0; cfg_rcr = 0; cfg_en = 1;
    run_measure(30, period);
    check("uev_period_updown", period, 6);

    // ARR preload vs write-through
    do_reset();
    cfg_mode = 0; cfg_psc = 0; cfg_arr = 3; cfg_arpe = 1; cfg_en = 1;
    step(); step();
    cfg_arr = 7;
    step();
    check("arr_shadow_hold", arr_act, 3);
    found = 0;
    for (int i = 0; i < 20; i++) if (!found) begin step(); found = uev; end
    check("arr_shadow_uev_seen", found, 1);
    check("arr_shadow_loaded", arr_act, 7);
    cfg_arpe = 0; cfg_arr = 3;
    step();
    check("arr_write_through", arr_act, 3);

    // one-pulse mode
    do_reset();
    cfg_arpe = 1; cfg_arr = 2; cfg_psc = 0; cfg_opm = 1; cfg_en = 1;
    found = 0;
    for (int i = 0; i < 20; i++) if (!found) begin step(); found = uev; end
    check("opm_uev_seen", found, 1);
    check("opm_busy", busy, 0);
    check("opm_pwm_en", pwm_en, 0);
    step();
    check("opm_stays_done", pwm_en, 0);
    cfg_en = 0; step();
    cfg_en = 1; step();
    check("opm_rearm", pwm_en, 1);

    // ug coincident with overflow at cnt=2
    do_reset();
    cfg_opm = 0; cfg_arr = 2; cfg_psc = 1; cfg_rcr = 0; cfg_en = 1;
    found = 0;
    for (int i = 0; i < 40; i++)
      if (!found) begin
        step();
        found = (m_st == M_RUN) && (m_div == m_psc) && (e_cnt == 2);
      end
    check("ug_ovf_reached", found, 1);
    ug = 1; uif_clr = 1;
    step();
    check("ug_uev", uev, 1);
    check("ug_pwm_low", pwm_en, 0);
    check("ug_uif_set_wins", uif, 1);
    ug = 0; uif_clr = 0;
    step();
    check("ug_single_pulse", uev, 0);
    check("ug_pwm_back", pwm_en, 1);
    check("ug_psc_cleared", tick, 0);
    step();
    check("ug_psc_tick", tick, 1);
    rst = 1;
    step();
    rst = 0;
    check("rst_pwm_en", pwm_en, 0);
    check("rst_uif", uif, 0);
    check("rst_arr_act", arr_act, 0);
    check("rst_busy", busy, 0);

    // randomized run against the model
    cfg_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29, 0) == 0) begin
        cfg_arr  = 16'($urandom_range(7, 0));
        cfg_psc  = 16'($urandom_range(3, 0));
        cfg_rcr  = 8'($urandom_range(3, 0));
        cfg_mode = 1'($urandom_range(1, 0));
        cfg_opm  = ($urandom_range(3, 0) == 0);
        cfg_arpe = 1'($urandom_range(1, 0));
      end
      if ($urandom_range(59, 0) == 0) cfg_en = ~cfg_en;
      ug      = ($urandom_range(39, 0) == 0);
      uif_clr = ($urandom_range(7, 0) == 0);
      rst     = ($urandom_range(499, 0) == 0);
      step();
    end
    rst = 0; ug = 0; uif_clr = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
